// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Purpose : bundles the instruction-memory read channel and the decode
//           valid/ready channel of the fetch stage.
// Signals : mem_req/mem_addr   fetch -> memory   read request and address
//           mem_ack/mem_rdata  memory -> fetch   data return strobe and word
//           instr_valid/instr/instr_pc  fetch -> decode  fetched instruction
//           instr_ready        decode -> fetch   decode accepts instruction
// Modports: master = fetch stage side, slave = memory/decode side.
// ---------------------------------------------------------------------------
interface instr_fetch_if #(
   parameter int WIDTH = 32
);
   logic             mem_req;
   logic [WIDTH-1:0] mem_addr;
   logic             mem_ack;
   logic [WIDTH-1:0] mem_rdata;
   logic             instr_valid;
   logic [WIDTH-1:0] instr;
   logic [WIDTH-1:0] instr_pc;
   logic             instr_ready;

   modport master (
      output mem_req, mem_addr, instr_valid, instr, instr_pc,
      input  mem_ack, mem_rdata, instr_ready
   );

   modport slave (
      input  mem_req, mem_addr, instr_valid, instr, instr_pc,
      output mem_ack, mem_rdata, instr_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Purpose : fetch stage behind the PC register. Requests the word at pc from
//           instruction memory, hands it to decode with valid/ready, computes
//           the next PC (pc+4 or a branch target) and pulses pc_load_o so the
//           PC register takes next_pc_o. Misaligned PCs and memory timeouts
//           end in a sticky fault that only rst clears.
// Ports   : clk, rst            clock, asynchronous active-high reset
//           pc_i                current PC register value
//           branch_taken_i      redirect request
//           branch_target_i     redirect address
//           bus (master)        memory req/ack and decode valid/ready channel
//           next_pc_o           value for the PC register input
//           pc_load_o           one-cycle load pulse for the PC register
//           fetch_fault_o       sticky fault flag
// ---------------------------------------------------------------------------
module instr_fetch #(
   parameter int WIDTH    = 32,
   parameter int WAIT_MAX = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pc_i,
   input  logic             branch_taken_i,
   input  logic [WIDTH-1:0] branch_target_i,
   instr_fetch_if.master    bus,
   output logic [WIDTH-1:0] next_pc_o,
   output logic             pc_load_o,
   output logic             fetch_fault_o
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_HOLD    = 3'd2;
   localparam logic [2:0] S_ADVANCE = 3'd3;
   localparam logic [2:0] S_FAULT   = 3'd4;

   // Counter value seen on the last FETCH cycle allowed without an ack.
   localparam logic [7:0]       WAIT_LAST = 8'(WAIT_MAX - 1);
   localparam logic [WIDTH-1:0] PC_STEP   = WIDTH'(4);

   logic [2:0]       state_q,       state_d;
   logic [7:0]       cnt_q,         cnt_d;
   logic             redir_q,       redir_d;
   logic [WIDTH-1:0] target_q,      target_d;
   logic             mem_req_q,     mem_req_d;
   logic [WIDTH-1:0] mem_addr_q,    mem_addr_d;
   logic             instr_valid_q, instr_valid_d;
   logic [WIDTH-1:0] instr_q,       instr_d;
   logic [WIDTH-1:0] instr_pc_q,    instr_pc_d;
   logic [WIDTH-1:0] next_pc_q,     next_pc_d;
   logic             pc_load_q,     pc_load_d;
   logic             fault_q,       fault_d;

   // A branch arriving in the ack cycle still counts and is the latest one.
   logic             redir_now_s;
   logic [WIDTH-1:0] redir_tgt_s;

   assign redir_now_s = redir_q | branch_taken_i;
   assign redir_tgt_s = branch_taken_i ? branch_target_i : target_q;

   // Next-state and registered-output computation for the fetch FSM.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      redir_d       = redir_q;
      target_d      = target_q;
      mem_req_d     = mem_req_q;
      mem_addr_d    = mem_addr_q;
      instr_valid_d = instr_valid_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      next_pc_d     = next_pc_q;
      pc_load_d     = pc_load_q;
      fault_d       = fault_q;

      case (state_q)
         S_IDLE: begin
            cnt_d = 8'd0;
            if (pc_i[1:0] != 2'b00) begin
               state_d = S_FAULT;
               fault_d = 1'b1;
            end else begin
               state_d    = S_FETCH;
               mem_req_d  = 1'b1;
               mem_addr_d = pc_i;
            end
         end

         S_FETCH: begin
            // Branches during the request are remembered; the transaction
            // itself always runs to its ack.
            if (branch_taken_i) begin
               redir_d  = 1'b1;
               target_d = branch_target_i;
            end else begin
               redir_d  = redir_q;
            end
            if (bus.mem_ack) begin
               mem_req_d = 1'b0;
               if (redir_now_s) begin
                  next_pc_d = redir_tgt_s;
                  pc_load_d = 1'b1;
                  state_d   = S_ADVANCE;
               end else begin
                  instr_d       = bus.mem_rdata;
                  instr_pc_d    = mem_addr_q;
                  instr_valid_d = 1'b1;
                  state_d       = S_HOLD;
               end
            end else if (cnt_q == WAIT_LAST) begin
               mem_req_d = 1'b0;
               fault_d   = 1'b1;
               state_d   = S_FAULT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         S_HOLD: begin
            // A branch outranks the decode handshake and drops the word.
            if (branch_taken_i) begin
               instr_valid_d = 1'b0;
               next_pc_d     = branch_target_i;
               pc_load_d     = 1'b1;
               state_d       = S_ADVANCE;
            end else if (bus.instr_ready) begin
               instr_valid_d = 1'b0;
               next_pc_d     = instr_pc_q + PC_STEP;
               pc_load_d     = 1'b1;
               state_d       = S_ADVANCE;
            end else begin
               state_d = S_HOLD;
            end
         end

         S_ADVANCE: begin
            pc_load_d = 1'b0;
            redir_d   = 1'b0;
            state_d   = S_IDLE;
         end

         S_FAULT: begin
            mem_req_d     = 1'b0;
            instr_valid_d = 1'b0;
            pc_load_d     = 1'b0;
            fault_d       = 1'b1;
            state_d       = S_FAULT;
         end

         // An unreachable encoding is treated as a fault rather than guessed.
         default: begin
            mem_req_d     = 1'b0;
            instr_valid_d = 1'b0;
            pc_load_d     = 1'b0;
            fault_d       = 1'b1;
            state_d       = S_FAULT;
         end
      endcase
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= 8'd0;
         redir_q       <= 1'b0;
         target_q      <= '0;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= '0;
         instr_valid_q <= 1'b0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         next_pc_q     <= '0;
         pc_load_q     <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         redir_q       <= redir_d;
         target_q      <= target_d;
         mem_req_q     <= mem_req_d;
         mem_addr_q    <= mem_addr_d;
         instr_valid_q <= instr_valid_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         next_pc_q     <= next_pc_d;
         pc_load_q     <= pc_load_d;
         fault_q       <= fault_d;
      end
   end

   assign bus.mem_req     = mem_req_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign next_pc_o       = next_pc_q;
   assign pc_load_o       = pc_load_q;
   assign fetch_fault_o   = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Purpose : self-checking bench for instr_fetch. Acts as PC register,
//           instruction memory and decode; each fetch is described by a few
//           parameters (ack latency, branches, ready delay) and the expected
//           addresses, data and next PC follow directly from those.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_i;
   logic        branch_taken_i;
   logic [31:0] branch_target_i;
   logic [31:0] next_pc_o;
   logic        pc_load_o;
   logic        fetch_fault_o;

   logic [31:0] pc_reg;
   int          n_checks = 0;
   int          n_errors = 0;

   instr_fetch_if #(.WIDTH(32)) bus ();

   instr_fetch #(.WIDTH(32), .WAIT_MAX(15)) dut (
      .clk             (clk),
      .rst             (rst),
      .pc_i            (pc_i),
      .branch_taken_i  (branch_taken_i),
      .branch_target_i (branch_target_i),
      .bus             (bus),
      .next_pc_o       (next_pc_o),
      .pc_load_o       (pc_load_o),
      .fetch_fault_o   (fetch_fault_o)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_req"},   32'(bus.mem_req),     32'd0);
      chk({tag, "_addr"},  bus.mem_addr,         32'd0);
      chk({tag, "_ivld"},  32'(bus.instr_valid), 32'd0);
      chk({tag, "_instr"}, bus.instr,            32'd0);
      chk({tag, "_ipc"},   bus.instr_pc,         32'd0);
      chk({tag, "_npc"},   next_pc_o,            32'd0);
      chk({tag, "_load"},  32'(pc_load_o),       32'd0);
      chk({tag, "_fault"}, 32'(fetch_fault_o),   32'd0);
   endtask

   task automatic idle_inputs();
      branch_taken_i   = 1'b0;
      branch_target_i  = 32'd0;
      bus.mem_ack      = 1'b0;
      bus.mem_rdata    = 32'd0;
      bus.instr_ready  = 1'b0;
   endtask

   // Enters with rst already high or low; leaves at a negedge in IDLE.
   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One complete fetch. Called at a negedge while the DUT is in IDLE and
   // returns at the negedge of the following IDLE cycle with pc_reg updated.
   //   lat     : FETCH cycle (1-based) in which mem_ack is given
   //   fb_cyc  : FETCH cycle with a directed branch (0 = none)
   //   rnd_br  : allow extra random branches during FETCH
   //   rdy_dly : HOLD cycles before instr_ready
   //   hb      : branch in the cycle instr_ready is given
   task automatic run_fetch(input int lat, input int fb_cyc, input logic [31:0] fb_tgt,
                            input logic rnd_br, input int rdy_dly,
                            input logic hb, input logic [31:0] hb_tgt);
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] tgt;
      logic [31:0] exp_next;
      logic        redir;
      addr  = pc_reg;
      data  = $urandom();
      tgt   = 32'd0;
      redir = 1'b0;
      pc_i  = pc_reg;
      idle_inputs();
      @(negedge clk);
      for (int k = 1; k <= lat; k++) begin
         chk("fetch_req",   32'(bus.mem_req),     32'd1);
         chk("fetch_addr",  bus.mem_addr,         addr);
         chk("fetch_ivld",  32'(bus.instr_valid), 32'd0);
         chk("fetch_fault", 32'(fetch_fault_o),   32'd0);
         bus.mem_ack     = (k == lat);
         bus.mem_rdata   = (k == lat) ? data : $urandom();
         branch_taken_i  = 1'b0;
         branch_target_i = $urandom();
         if (k == fb_cyc) begin
            branch_taken_i  = 1'b1;
            branch_target_i = fb_tgt;
         end else if (rnd_br && ($urandom_range(0, 3) == 0)) begin
            branch_taken_i  = 1'b1;
            branch_target_i = $urandom() & 32'hFFFF_FFFC;
         end else begin
            branch_taken_i  = 1'b0;
         end
         if (branch_taken_i) begin
            redir = 1'b1;
            tgt   = branch_target_i;
         end
         @(negedge clk);
      end
      bus.mem_ack    = 1'b0;
      branch_taken_i = 1'b0;
      chk("req_drop", 32'(bus.mem_req), 32'd0);
      if (redir) begin
         exp_next = tgt;
         chk("redir_ivld", 32'(bus.instr_valid), 32'd0);
      end else begin
         chk("hold_ivld",  32'(bus.instr_valid), 32'd1);
         chk("hold_instr", bus.instr,            data);
         chk("hold_ipc",   bus.instr_pc,         addr);
         chk("hold_load",  32'(pc_load_o),       32'd0);
         for (int j = 0; j < rdy_dly; j++) begin
            bus.instr_ready = 1'b0;
            @(negedge clk);
            chk("wait_ivld",  32'(bus.instr_valid), 32'd1);
            chk("wait_instr", bus.instr,            data);
         end
         bus.instr_ready = 1'b1;
         if (hb) begin
            branch_taken_i  = 1'b1;
            branch_target_i = hb_tgt;
            exp_next        = hb_tgt;
         end else begin
            exp_next        = addr + 32'd4;
         end
         @(negedge clk);
         bus.instr_ready = 1'b0;
         branch_taken_i  = 1'b0;
      end
      chk("adv_load", 32'(pc_load_o),       32'd1);
      chk("adv_npc",  next_pc_o,            exp_next);
      chk("adv_ivld", 32'(bus.instr_valid), 32'd0);
      // A branch while advancing must have no effect.
      branch_taken_i  = $urandom_range(0, 1) == 1;
      branch_target_i = $urandom() & 32'hFFFF_FFFC;
      @(negedge clk);
      branch_taken_i = 1'b0;
      chk("idle_load", 32'(pc_load_o),   32'd0);
      chk("idle_req",  32'(bus.mem_req), 32'd0);
      pc_reg = exp_next;
      pc_i   = pc_reg;
   endtask

   initial begin
      pc_reg = 32'd0;
      pc_i   = 32'd0;
      idle_inputs();

      // Sequential fetches from 0: next_pc 4, 8, 12.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         run_fetch(1, 0, 32'd0, 1'b0, 0, 1'b0, 32'd0);
      end
      chk("seq_pc", pc_reg, 32'd12);

      // Branch in HOLD together with instr_ready.
      run_fetch(1, 0, 32'd0, 1'b0, 0, 1'b1, 32'h0000_0100);
      // Branch in FETCH, ack three cycles later.
      run_fetch(4, 1, 32'h0000_0040, 1'b0, 0, 1'b0, 32'd0);
      // Ack on the 14th FETCH cycle is still in time.
      run_fetch(14, 0, 32'd0, 1'b0, 1, 1'b0, 32'd0);

      // Randomised fetches.
      for (int i = 0; i < 40; i++) begin
         run_fetch($urandom_range(1, 14), 0, 32'd0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 3), $urandom_range(0, 4) == 0,
                   $urandom() & 32'hFFFF_FFFC);
      end

      // Wrap at the top of the address space.
      pc_reg = 32'hFFFF_FFFC;
      run_fetch(1, 0, 32'd0, 1'b0, 0, 1'b0, 32'd0);
      chk("wrap_pc", pc_reg, 32'd0);

      // Reset in the middle of a FETCH clears outputs immediately.
      pc_reg = 32'h0000_0200;
      pc_i   = pc_reg;
      @(negedge clk);
      chk("mid_req", 32'(bus.mem_req), 32'd1);
      rst = 1'b1;
      #1;
      chk_zero("async_rst");
      do_reset();
      pc_reg = 32'h0000_0300;
      run_fetch(2, 0, 32'd0, 1'b0, 0, 1'b0, 32'd0);

      // No ack: fault after 15 FETCH cycles, then sticky.
      do_reset();
      pc_reg = 32'h0000_0010;
      pc_i   = pc_reg;
      @(negedge clk);
      for (int k = 1; k <= 15; k++) begin
         chk("to_req",   32'(bus.mem_req),   32'd1);
         chk("to_fault", 32'(fetch_fault_o), 32'd0);
         @(negedge clk);
      end
      chk("to_fault_set", 32'(fetch_fault_o), 32'd1);
      chk("to_req_off",   32'(bus.mem_req),   32'd0);
      bus.mem_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("to_sticky", 32'(fetch_fault_o),   32'd1);
         chk("to_ivld",   32'(bus.instr_valid), 32'd0);
      end

      // Misaligned PC: fault without a request.
      pc_reg = 32'h0000_0006;
      pc_i   = pc_reg;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("mis_req",   32'(bus.mem_req),   32'd0);
         chk("mis_fault", 32'(fetch_fault_o), 32'd1);
         chk("mis_load",  32'(pc_load_o),     32'd0);
      end
      do_reset();
      chk("mis_clear", 32'(fetch_fault_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
